l2_ifill: RTL and testbench

- L2-side instruction refill responder; it is the far end of the icache's L2_block_read / L2_addr_read / L2_stall interface.
- Accepts a block miss request from the L1I cache and fetches the 256-bit (8-word) block over a 32-bit single-outstanding memory bus, critical word first.
- Drives the block, its aligned address and L2_stall back to the icache, and retains the last filled block so an immediate re-request returns without a refill.

---
 rtl/l2_ifill.sv | 127 ++++++++++++
 tb/tb_l2_ifill.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_ifill.sv
// ---------------------------------------------------------------------------
// l2_ifill
//
// L2-side instruction refill responder. It sits at the far end of the icache
// miss interface: when the icache raises ic_req for a block that is not the
// one currently held, the block is fetched one 32-bit word at a time over a
// single-outstanding memory bus and assembled into L2_block_read. With
// CRIT_FIRST set, the fetch starts at the word the icache asked for and wraps
// around the 8-word block; otherwise it always starts at word 0.
//
// The last completed block is retained, so a repeated request for the same
// block is answered immediately without touching memory.
//
// Ports:
//   clk            global clock
//   rst_n          asynchronous active-low reset
//   ic_req         icache miss request (level, held while the icache waits)
//   ic_addr        miss byte address; bits [4:2] pick the critical word
//   L2_block_read  256-bit block, word i in bits [32i+31:32i]
//   L2_addr_read   block-aligned address of L2_block_read
//   L2_stall       high while a fill is in progress
//   L2_fill_valid  L2_block_read holds a complete block for L2_addr_read
//   mem_req        memory word read request
//   mem_addr       memory word address {block, word index, 2'b00}
//   mem_gnt        memory accepted mem_req this cycle
//   mem_rvalid     memory read data valid
//   mem_rdata      memory read data
// ---------------------------------------------------------------------------
module l2_ifill #(
  parameter bit CRIT_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_req,
  input  logic [31:0]  ic_addr,
  output logic [255:0] L2_block_read,
  output logic [31:0]  L2_addr_read,
  output logic         L2_stall,
  output logic         L2_fill_valid,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [2:0]  count;
  logic        buf_hit;
  logic        unused_addr_bits;

  // Byte-offset bits never matter: requests are for whole blocks.
  assign unused_addr_bits = ^ic_addr[1:0];

  // A request for the block already held (and complete) needs no refill.
  assign buf_hit = L2_fill_valid && (ic_addr[31:5] == L2_addr_read[31:5]);

  // The memory request is decoded purely from registered state so mem_addr
  // stays stable for as long as the memory holds off mem_gnt.
  assign mem_req  = (state == S_ISSUE);
  assign mem_addr = {L2_addr_read[31:5], idx, 2'b00};

  // Fill sequencer. Alternates ISSUE (request one word) and WAIT (collect
  // its data) until all 8 words have landed. The accepted block address is
  // latched at the start, so later ic_req/ic_addr activity cannot disturb an
  // ongoing fill; only reset aborts it. Read data is taken in WAIT only, so a
  // response that arrives in IDLE or ISSUE (e.g. left over from before a
  // reset) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      L2_block_read <= '0;
      L2_addr_read  <= '0;
      L2_stall      <= 1'b0;
      L2_fill_valid <= 1'b0;
      idx           <= 3'd0;
      count         <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ic_req && !buf_hit) begin
            L2_addr_read  <= {ic_addr[31:5], 5'b0};
            L2_fill_valid <= 1'b0;
            L2_stall      <= 1'b1;
            idx           <= CRIT_FIRST ? ic_addr[4:2] : 3'd0;
            count         <= 3'd0;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mem_gnt) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            L2_block_read[{idx, 5'b0} +: 32] <= mem_rdata;
            // 3-bit index wraps 7 -> 0 for critical-word-first order
            idx   <= idx + 3'd1;
            count <= count + 3'd1;
            if (count == 3'd7) begin
              L2_stall      <= 1'b0;
              L2_fill_valid <= 1'b1;
              state         <= S_IDLE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_ifill.sv
// ---------------------------------------------------------------------------
// tb_l2_ifill
//
// Directed-plus-random bench for l2_ifill. Two instances are used: the main
// one with critical-word-first ordering, and a second with CRIT_FIRST=0.
// Each has a memory responder that returns the word address as data, so a
// correctly filled block at base B holds B+4i in word i. Expected grant order
// is derived from the start word and the modulo-8 wrap rule.
// ---------------------------------------------------------------------------
module tb_l2_ifill;

  logic         clk;
  logic         rst_n;

  // main instance (critical word first)
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic [255:0] L2_block_read;
  logic [31:0]  L2_addr_read;
  logic         L2_stall;
  logic         L2_fill_valid;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  // second instance (always starts at word 0)
  logic         ic_req_z;
  logic [31:0]  ic_addr_z;
  logic [255:0] L2_block_read_z;
  logic [31:0]  L2_addr_read_z;
  logic         L2_stall_z;
  logic         L2_fill_valid_z;
  logic         mem_req_z;
  logic [31:0]  mem_addr_z;
  logic         mem_gnt_z;
  logic         mem_rvalid_z;
  logic [31:0]  mem_rdata_z;

  // memory responder controls and logs
  int           gnt_max;
  int           rv_min;
  int           rv_max;
  bit           spur_en;
  logic [31:0]  grant_q[$];
  logic [31:0]  grant_z_q[$];

  int           cmp_cnt;
  int           err_cnt;

  l2_ifill #(.CRIT_FIRST(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .L2_block_read (L2_block_read),
    .L2_addr_read  (L2_addr_read),
    .L2_stall      (L2_stall),
    .L2_fill_valid (L2_fill_valid),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  l2_ifill #(.CRIT_FIRST(1'b0)) dut_z (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_req        (ic_req_z),
    .ic_addr       (ic_addr_z),
    .L2_block_read (L2_block_read_z),
    .L2_addr_read  (L2_addr_read_z),
    .L2_stall      (L2_stall_z),
    .L2_fill_valid (L2_fill_valid_z),
    .mem_req       (mem_req_z),
    .mem_addr      (mem_addr_z),
    .mem_gnt       (mem_gnt_z),
    .mem_rvalid    (mem_rvalid_z),
    .mem_rdata     (mem_rdata_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for the main instance: grants after 0..gnt_max idle cycles,
  // answers rv_min..rv_max cycles after the grant, optionally throws junk
  // rvalid pulses whenever nothing is outstanding. It does not notice reset,
  // so a response in flight at reset is still delivered afterwards.
  initial begin : mem_model
    bit          pending;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] pend_addr;
    pending   = 1'b0;
    gnt_wait  = 0;
    rv_wait   = 0;
    pend_addr = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (pending) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_addr;
          pending    = 1'b0;
        end else begin
          rv_wait--;
        end
      end else begin
        if (mem_req) begin
          if (gnt_wait == 0) begin
            mem_gnt   = 1'b1;
            pending   = 1'b1;
            pend_addr = mem_addr;
            grant_q.push_back(mem_addr);
            rv_wait   = $urandom_range(rv_max, rv_min);
            gnt_wait  = $urandom_range(gnt_max, 0);
          end else begin
            gnt_wait--;
          end
        end
        if (spur_en && ($urandom_range(2, 0) == 0)) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0_0000 | ($urandom() & 32'h0000_FFFF);
        end
      end
    end
  end

  // Zero-wait memory for the word-0-first instance.
  initial begin : mem_model_z
    bit          pending;
    logic [31:0] pend_addr;
    pending      = 1'b0;
    pend_addr    = '0;
    mem_gnt_z    = 1'b0;
    mem_rvalid_z = 1'b0;
    mem_rdata_z  = '0;
    forever begin
      @(negedge clk);
      mem_gnt_z    = 1'b0;
      mem_rvalid_z = 1'b0;
      if (pending) begin
        mem_rvalid_z = 1'b1;
        mem_rdata_z  = pend_addr;
        pending      = 1'b0;
      end else if (mem_req_z) begin
        mem_gnt_z = 1'b1;
        pending   = 1'b1;
        pend_addr = mem_addr_z;
        grant_z_q.push_back(mem_addr_z);
      end
    end
  end

  // Block image a correct fill of base must produce.
  function automatic logic [255:0] exp_block(input logic [31:0] base);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = base + 32'(4 * i);
    return b;
  endfunction

  task automatic check_output(input string tag, input logic [255:0] obs,
                              input logic [255:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic [31:0] addr);
    ic_req  = req;
    ic_addr = addr;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_block"}, L2_block_read, 256'd0);
    check_output({tag, "_addr"}, {224'd0, L2_addr_read}, 256'd0);
    check_output({tag, "_stall"}, {255'd0, L2_stall}, 256'd0);
    check_output({tag, "_valid"}, {255'd0, L2_fill_valid}, 256'd0);
    check_output({tag, "_memreq"}, {255'd0, mem_req}, 256'd0);
  endtask

  // Steps negedge by negedge until the fill completes, counting stall cycles.
  task automatic wait_fill(output int stalls);
    int n;
    stalls = 0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (L2_fill_valid) break;
      if (L2_stall) stalls++;
    end
    check_output("fill_timeout", {255'd0, (n >= 3000)}, 256'd0);
  endtask

  // Completed-fill checks: outputs, block image and word fetch order.
  task automatic check_fill(input string tag, input logic [31:0] addr,
                            input int start, input int g0);
    logic [31:0] base;
    int          n;
    base = {addr[31:5], 5'b0};
    check_output({tag, "_addr"}, {224'd0, L2_addr_read}, {224'd0, base});
    check_output({tag, "_valid"}, {255'd0, L2_fill_valid}, 256'd1);
    check_output({tag, "_stall"}, {255'd0, L2_stall}, 256'd0);
    check_output({tag, "_block"}, L2_block_read, exp_block(base));
    n = grant_q.size() - g0;
    check_output({tag, "_ngrants"}, 256'(n), 256'd8);
    for (int k = 0; k < 8 && k < n; k++)
      check_output($sformatf("%s_grant%0d", tag, k), {224'd0, grant_q[g0 + k]},
                   {224'd0, base + 32'(4 * ((start + k) % 8))});
  endtask

  initial begin : main
    int          g0;
    int          g1;
    int          stalls;
    int          n;
    int          req_seen;
    int          stall_seen;
    logic [31:0] a;

    cmp_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b1;
    ic_req    = 1'b0;
    ic_addr   = '0;
    ic_req_z  = 1'b0;
    ic_addr_z = '0;
    gnt_max   = 0;
    rv_min    = 0;
    rv_max    = 0;
    spur_en   = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Critical-word-first fill, zero-wait memory
    $display("[TB] step 1: critical word first fill of 0x1014");
    g0 = grant_q.size();
    apply_stimulus(1'b1, 32'h0000_1014);
    wait_fill(stalls);
    check_output("t1_stall_cycles", 256'(stalls), 256'd16);
    check_fill("t1", 32'h0000_1014, 5, g0);

    // Same block again: answered from the held block
    $display("[TB] step 2: buffer hit on 0x101C");
    g0 = grant_q.size();
    apply_stimulus(1'b1, 32'h0000_101C);
    req_seen   = 0;
    stall_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) req_seen++;
      if (L2_stall) stall_seen++;
    end
    check_output("t2_memreq", 256'(req_seen), 256'd0);
    check_output("t2_stall", 256'(stall_seen), 256'd0);
    check_output("t2_ngrants", 256'(grant_q.size() - g0), 256'd0);
    check_output("t2_block", L2_block_read, exp_block(32'h0000_1000));
    check_output("t2_addr", {224'd0, L2_addr_read}, {224'd0, 32'h0000_1000});

    // Word-0-first instance
    $display("[TB] step 3: word 0 first fill of 0x2008");
    ic_req_z  = 1'b1;
    ic_addr_z = 32'h0000_2008;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (L2_fill_valid_z) break;
    end
    check_output("t3_timeout", {255'd0, (n >= 200)}, 256'd0);
    check_output("t3_ngrants", 256'(grant_z_q.size()), 256'd8);
    if (grant_z_q.size() == 8) begin
      check_output("t3_first", {224'd0, grant_z_q[0]}, {224'd0, 32'h0000_2000});
      check_output("t3_last", {224'd0, grant_z_q[7]}, {224'd0, 32'h0000_201C});
    end
    check_output("t3_block", L2_block_read_z, exp_block(32'h0000_2000));
    check_output("t3_addr", {224'd0, L2_addr_read_z}, {224'd0, 32'h0000_2000});
    ic_req_z = 1'b0;

    // Random memory delays with junk rvalid pulses
    $display("[TB] step 4: random memory timing");
    spur_en = 1'b1;
    gnt_max = 5;
    rv_max  = 5;
    for (int it = 0; it < 4; it++) begin
      a = $urandom();
      if (a[31:5] == L2_addr_read[31:5]) a[31] = ~a[31];
      g0 = grant_q.size();
      apply_stimulus(1'b1, a);
      wait_fill(stalls);
      check_fill($sformatf("t4_%0d", it), a, int'(a[4:2]), g0);
    end

    // Reset mid-fill with a response still in flight
    $display("[TB] step 5: reset during fill");
    spur_en = 1'b0;
    gnt_max = 0;
    rv_min  = 3;
    rv_max  = 3;
    @(negedge clk);
    g0 = grant_q.size();
    apply_stimulus(1'b1, 32'h0000_4008);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (grant_q.size() >= g0 + 5) break;
    end
    check_output("t5_timeout", {255'd0, (n >= 200)}, 256'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    ic_req = 1'b0;
    #1;
    check_reset("t5_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_reset("t5_stale");
    rv_min = 0;
    rv_max = 0;
    g0 = grant_q.size();
    apply_stimulus(1'b1, 32'h0000_4008);
    wait_fill(stalls);
    check_output("t5_stall_cycles", 256'(stalls), 256'd16);
    check_fill("t5_refill", 32'h0000_4008, 2, g0);

    // Address change mid-fill, then the new block right after completion
    $display("[TB] step 6: ic_addr change during fill");
    g0 = grant_q.size();
    apply_stimulus(1'b1, 32'h0000_1000);
    repeat (5) @(negedge clk);
    apply_stimulus(1'b1, 32'h0000_3000);
    wait_fill(stalls);
    check_fill("t6_keep", 32'h0000_1000, 0, g0);
    g1 = grant_q.size();
    @(negedge clk);
    check_output("t6_next_stall", {255'd0, L2_stall}, 256'd1);
    check_output("t6_next_valid", {255'd0, L2_fill_valid}, 256'd0);
    check_output("t6_next_addr", {224'd0, L2_addr_read}, {224'd0, 32'h0000_3000});
    wait_fill(stalls);
    check_fill("t6_new", 32'h0000_3000, 0, g1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
